iir_result_writer: RTL and testbench

- Downstream stage of the IIR filter. Accepts the filter's output sample stream: Yn, the write strobe and the write address.
- Buffers samples in a small FIFO and drains them to the result memory over a req/ack write port that may stall.
- Signals done once the filter reports finish and every accepted sample has been written.
- Reports dropped samples with a sticky overflow flag, because the filter has no backpressure.

---
 rtl/iir_wr_pkg.sv | 20 ++
 rtl/iir_wr_fifo.sv | 53 +++++
 rtl/iir_result_writer.sv | 143 ++++++++++++++
 tb/tb_iir_result_writer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_wr_pkg.sv
// rtl/iir_wr_pkg.sv - shared types and default sizes for the IIR result writer
package iir_wr_pkg;

    localparam int DEF_AW    = 20;
    localparam int DEF_DW    = 16;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wr_state_t;

    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/iir_wr_fifo.sv
// rtl/iir_wr_fifo.sv - synchronous FIFO exposing the head and the entry behind it
module iir_wr_fifo
    import iir_wr_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = DEF_AW + DEF_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head,
    output logic [W-1:0]             peek1
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-2:0] rd_idx_nx;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign count     = wr_ptr - rd_ptr;
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign rd_idx_nx = rd_ptr[PW-2:0] + (PW-1)'(1);
    assign head      = mem[rd_ptr[PW-2:0]];
    assign peek1     = mem[rd_idx_nx];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-2:0]] <= wdata;
    end

endmodule

// File: rtl/iir_result_writer.sv
// rtl/iir_result_writer.sv - buffers IIR output samples and drains them to memory; IIR_WR_PEAK_EN adds peak_abs
module iir_result_writer
    import iir_wr_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_wen,
    input  logic [DW-1:0] in_data,
    input  logic [AW-1:0] in_addr,
    input  logic          in_finish,
    output logic          in_ready,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic          mem_ack,
    output logic          done,
    output logic          overflow,
    output logic [AW-1:0] wr_count
`ifdef IIR_WR_PEAK_EN
    ,
    output logic [DW-2:0] peak_abs
`endif
);

    localparam int PW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    localparam int EW = $bits(entry_t);

    wr_state_t     state;
    wr_state_t     state_nx;
    entry_t        in_entry;
    entry_t        head;
    entry_t        peek1;
    entry_t        present_nx;
    logic          full;
    logic          empty;
    logic [PW-1:0] count;
    logic          accepting;
    logic          push;
    logic          pop;
    logic          drop;
    logic          head_keeps;
    logic          fill_nx;

    // The presented write is always the FIFO head; it leaves the FIFO only on ack.
    assign in_entry   = '{addr: in_addr, data: in_data};
    assign accepting  = (state != DONE);
    assign pop        = mem_wr && mem_ack;
    assign push       = in_wen && accepting && (!full || pop);
    assign drop       = in_wen && accepting && full && !pop;
    assign head_keeps = !empty && !(pop && count == PW'(1));
    assign fill_nx    = head_keeps || push;
    assign in_ready   = !full;
    assign done       = (state == DONE);

    always_comb begin
        present_nx = in_entry;
        if (head_keeps) present_nx = pop ? peek1 : head;
    end

    iir_wr_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_entry),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head),
        .peek1 (peek1)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (in_finish)   state_nx = DRAIN;
                else if (in_wen) state_nx = RUN;
            end
            RUN:     if (in_finish) state_nx = DRAIN;
            DRAIN:   if (empty && !push) state_nx = DONE;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            overflow <= 1'b0;
            wr_count <= '0;
        end else begin
            state  <= state_nx;
            mem_wr <= fill_nx;
            if (fill_nx) begin
                mem_addr <= present_nx.addr;
                mem_data <= present_nx.data;
            end
            if (drop) overflow <= 1'b1;
            if (pop)  wr_count <= wr_count + AW'(1);
        end
    end

`ifdef IIR_WR_PEAK_EN
    logic [DW-2:0] neg_low;
    logic [DW-2:0] cur_abs;

    // The most negative sample has no positive twin, so it clamps to the largest magnitude.
    always_comb begin
        neg_low = ~mem_data[DW-2:0] + (DW-1)'(1);
        cur_abs = mem_data[DW-2:0];
        if (mem_data[DW-1]) begin
            if (mem_data[DW-2:0] == '0) cur_abs = '1;
            else                        cur_abs = neg_low;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_abs <= '0;
        end else if (pop && cur_abs > peak_abs) begin
            peak_abs <= cur_abs;
        end
    end
`endif

endmodule

// File: tb/tb_iir_result_writer.sv
// tb/tb_iir_result_writer.sv - self-checking bench for iir_result_writer
module tb_iir_result_writer;

    localparam int AW    = 20;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_wen;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_addr;
    logic          in_finish;
    logic          in_ready;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ack;
    logic          done;
    logic          overflow;
    logic [AW-1:0] wr_count;
`ifdef IIR_WR_PEAK_EN
    logic [DW-2:0] peak_abs;
`endif

    iir_result_writer #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_wen    (in_wen),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .in_finish (in_finish),
        .in_ready  (in_ready),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ack   (mem_ack),
        .done      (done),
        .overflow  (overflow),
        .wr_count  (wr_count)
`ifdef IIR_WR_PEAK_EN
        ,
        .peak_abs  (peak_abs)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-2:0] exp_peak;
    } vec_t;

    vec_t basic [5];
    vec_t peak  [4];

    int checks = 0;
    int errors = 0;

    logic [AW+DW-1:0] exp_q [$];
    logic [AW+DW-1:0] sb_exp;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Scoreboard: every completed write must match the oldest accepted sample.
    always @(negedge clk) begin
        if (!rst && mem_wr && mem_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %0h want no write", {mem_addr, mem_data});
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_write", {mem_addr, mem_data}, sb_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_wen    = 1'b0;
        in_finish = 1'b0;
        mem_ack   = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_sample(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit accept);
        in_wen  = 1'b1;
        in_addr = a;
        in_data = d;
        if (accept) exp_q.push_back({a, d});
        tick();
        in_wen = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (!done && n < max_cycles) begin
            tick();
            n++;
        end
        check("done_reached", done, 1);
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        basic[0] = '{addr: 20'd0, data: 16'h0001, exp_peak: 15'd1};
        basic[1] = '{addr: 20'd1, data: 16'hFFFF, exp_peak: 15'd1};
        basic[2] = '{addr: 20'd2, data: 16'h7FFF, exp_peak: 15'd32767};
        basic[3] = '{addr: 20'd3, data: 16'h8000, exp_peak: 15'd32767};
        basic[4] = '{addr: 20'd4, data: 16'h0000, exp_peak: 15'd32767};
        peak[0]  = '{addr: 20'd10, data: 16'hFFFD, exp_peak: 15'd3};
        peak[1]  = '{addr: 20'd11, data: 16'h00C8, exp_peak: 15'd200};
        peak[2]  = '{addr: 20'd12, data: 16'h8000, exp_peak: 15'd32767};
        peak[3]  = '{addr: 20'd13, data: 16'h0005, exp_peak: 15'd32767};

        // Reset state
        do_reset();
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef IIR_WR_PEAK_EN
        check("rst_peak", peak_abs, 0);
`endif

        // Basic flow, ack tied high: each write appears one cycle behind its push
        mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_sample(basic[i].addr, basic[i].data, 1'b1);
            check("basic_wr", mem_wr, 1);
            check("basic_addr", mem_addr, basic[i].addr);
            check("basic_data", mem_data, basic[i].data);
        end
        in_finish = 1'b1;
        wait_done(20);
        check("basic_count", wr_count, 5);
        check("basic_overflow", overflow, 0);
        check("basic_idle_wr", mem_wr, 0);
        check("basic_sb_empty", exp_q.size(), 0);
`ifdef IIR_WR_PEAK_EN
        check("basic_peak", peak_abs, basic[4].exp_peak);
`endif

        // Stall: head held stable for 20 cycles, then back-to-back drain
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push_sample(AW'(i), DW'(16'h1000 + i), 1'b1);
            check("stall_wr", mem_wr, 1);
            check("stall_addr0", mem_addr, 0);
            check("stall_ready", in_ready, (i < 7) ? 1 : 0);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            check("stall_hold", {mem_wr, mem_addr}, {1'b1, 20'd0});
        end
        mem_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("b2b_wr", mem_wr, 1);
            check("b2b_addr", mem_addr, k);
            tick();
        end
        check("b2b_idle_wr", mem_wr, 0);
        check("b2b_count", wr_count, 8);
        check("b2b_ready", in_ready, 1);
        in_finish = 1'b1;
        wait_done(20);

        // Overflow: samples 9 and 10 are lost, flag sticky through DONE
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push_sample(AW'(20 + i), DW'(16'h2000 + i), i < 8);
            check("ovf_flag", overflow, (i >= 8) ? 1 : 0);
        end
        check("ovf_count_stalled", wr_count, 0);
        mem_ack = 1'b1;
        wait_drain(40, "ovf_drain");
        in_finish = 1'b1;
        wait_done(20);
        check("ovf_sticky", overflow, 1);
        check("ovf_count", wr_count, 8);

        // Full FIFO with a completing ack and a push in the same cycle
        do_reset();
        for (int i = 0; i < 8; i++) push_sample(AW'(40 + i), DW'(16'h3000 + i), 1'b1);
        check("fullack_pre_ready", in_ready, 0);
        mem_ack = 1'b1;
        push_sample(20'd48, 16'h3008, 1'b1);
        mem_ack = 1'b0;
        check("fullack_ovf", overflow, 0);
        check("fullack_ready", in_ready, 0);
        check("fullack_head", mem_addr, 41);
        mem_ack = 1'b1;
        wait_drain(40, "fullack_drain");
        check("fullack_count", wr_count, 9);
        check("fullack_ovf_end", overflow, 0);
        in_finish = 1'b1;
        wait_done(20);

        // Reset mid-drain discards buffered samples
        do_reset();
        for (int i = 0; i < 5; i++) push_sample(AW'(60 + i), DW'(16'h4000 + i), 1'b1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("pre_rst_count", wr_count, 1);
        check("pre_rst_wr", mem_wr, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_wr", mem_wr, 0);
        check("mid_rst_count", wr_count, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ready", in_ready, 1);
        mem_ack = 1'b1;
        push_sample(20'd100, 16'h0100, 1'b1);
        check("post_rst_wr", mem_wr, 1);
        check("post_rst_addr", mem_addr, 100);
        wait_drain(10, "post_rst_drain");
        in_finish = 1'b1;
        wait_done(20);
        check("post_rst_count", wr_count, 1);

        // Ack without a pending write, finish with no data, DONE ignores input
        do_reset();
        mem_ack = 1'b1;
        repeat (3) tick();
        check("idle_ack_count", wr_count, 0);
        check("idle_ack_wr", mem_wr, 0);
        in_finish = 1'b1;
        wait_done(10);
        in_finish = 1'b0;
        for (int i = 0; i < 10; i++) push_sample(AW'(i), 16'h5555, 1'b0);
        check("done_ovf", overflow, 0);
        check("done_wr", mem_wr, 0);
        check("done_count", wr_count, 0);
        check("done_held", done, 1);

`ifdef IIR_WR_PEAK_EN
        // Peak magnitude tracks completed writes, most negative value saturates
        do_reset();
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_sample(peak[i].addr, peak[i].data, 1'b1);
            tick();
            check("peak_abs", peak_abs, peak[i].exp_peak);
        end
        in_finish = 1'b1;
        wait_done(20);
        check("peak_held", peak_abs, 15'd32767);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
